// File: rtl/nor_vector_checker_if.sv
// Bus between the NOR vector checker and the NOR stage under check.
// The environment owns start and y; the checker owns the stimulus and the results.
interface nor_vector_checker_if;
  logic       start;
  logic       y;
  logic       a;
  logic       b;
  logic       busy;
  logic       done;
  logic       pass;
  logic [2:0] err_count;
  logic [3:0] fail_mask;

  modport master (
    output start, y,
    input  a, b, busy, done, pass, err_count, fail_mask
  );

  modport slave (
    input  start, y,
    output a, b, busy, done, pass, err_count, fail_mask
  );
endinterface

// File: rtl/nor_vector_checker.sv
// Drives the four {a,b} vectors into a 2-input NOR stage, holding each one for SETTLE cycles.
// It samples y at the end of each hold, compares it against the NOR truth table and reports the result.
module nor_vector_checker #(
  parameter int unsigned SETTLE = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  nor_vector_checker_if.slave  bus
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned IDX_W = 2;
  localparam int unsigned ERR_W = 3;
  localparam int unsigned VEC_N = 4;
  localparam logic [VEC_N-1:0] EXP_Y    = 4'b0001;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SETTLE - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VEC_N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               a_q, a_d;
  logic               b_q, b_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               pass_q, pass_d;
  logic [ERR_W-1:0]   err_q, err_d;
  logic [VEC_N-1:0]   fail_q, fail_d;
  logic               mismatch_c;

  // Next-state and registered-output logic
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    a_d        = a_q;
    b_d        = b_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    pass_d     = pass_q;
    err_d      = err_q;
    fail_d     = fail_q;
    mismatch_c = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = RUN;
          cnt_d   = '0;
          idx_d   = '0;
          a_d     = 1'b0;
          b_d     = 1'b0;
          busy_d  = 1'b1;
          pass_d  = 1'b0;
          err_d   = '0;
          fail_d  = '0;
        end
      end
      RUN: begin
        if (cnt_q == LAST_CNT) begin
          // A y that is not a clean 0/1 never matches.
          mismatch_c = (bus.y !== EXP_Y[idx_q]);
          if (mismatch_c) begin
            err_d         = err_q + ERR_W'(1);
            fail_d[idx_q] = 1'b1;
          end
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            a_d     = 1'b0;
            b_d     = 1'b0;
            pass_d  = (err_d == ERR_W'(0));
          end else begin
            idx_d = idx_q + IDX_W'(1);
            cnt_d = '0;
            a_d   = idx_d[1];
            b_d   = idx_d[0];
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        a_d     = 1'b0;
        b_d     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      fail_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      fail_q  <= fail_d;
    end
  end

  assign bus.a         = a_q;
  assign bus.b         = b_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.err_count = err_q;
  assign bus.fail_mask = fail_q;

endmodule

// File: tb/tb_nor_vector_checker.sv
// Bench for nor_vector_checker: the stage under check is modelled as a 4-entry response table.
// Expected results come from that table XORed with the NOR truth table.
module tb_nor_vector_checker;

  localparam int S0 = 2;
  localparam int S1 = 1;
  localparam logic [3:0] NOR_TBL = 4'b0001;

  logic       clk;
  logic       rst;
  logic [3:0] rsp0;
  int         total;
  int         bad;

  nor_vector_checker_if if0 ();
  nor_vector_checker_if if1 ();

  nor_vector_checker #(.SETTLE(S0)) u_dut0 (.clk(clk), .rst(rst), .bus(if0));
  nor_vector_checker #(.SETTLE(S1)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));

  // Stage responses: dut0 follows a programmable table, dut1 is a correct NOR.
  assign if0.y = rsp0[{if0.a, if0.b}];
  assign if1.y = ~(if1.a | if1.b);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One full run on dut0, checking every cycle from E0 to E(4*S0+1).
  task automatic run0(input logic [3:0] r);
    logic [3:0] fm;
    logic [3:0] pm;
    int         k;
    fm   = r ^ NOR_TBL;
    rsp0 = r;
    @(negedge clk);
    if0.start = 1'b1;
    @(posedge clk);
    #1;
    if0.start = 1'b0;
    for (int t = 0; t <= 4 * S0 + 1; t++) begin
      if (t < 4 * S0) begin
        k  = t / S0;
        pm = '0;
        for (int j = 0; j < k; j++) pm[j] = fm[j];
        check_eq("run_busy", 32'(if0.busy), 32'd1);
        check_eq("run_done", 32'(if0.done), 32'd0);
        check_eq("run_a", 32'(if0.a), 32'((k >> 1) & 1));
        check_eq("run_b", 32'(if0.b), 32'(k & 1));
        check_eq("run_err", 32'(if0.err_count), 32'($countones(pm)));
        check_eq("run_mask", 32'(if0.fail_mask), 32'(pm));
        check_eq("run_pass", 32'(if0.pass), 32'd0);
      end else begin
        check_eq("end_busy", 32'(if0.busy), 32'd0);
        check_eq("end_done", 32'(if0.done), 32'(t == 4 * S0));
        check_eq("end_ab", 32'({if0.a, if0.b}), 32'd0);
        check_eq("end_err", 32'(if0.err_count), 32'($countones(fm)));
        check_eq("end_mask", 32'(if0.fail_mask), 32'(fm));
        check_eq("end_pass", 32'(if0.pass), 32'(fm == 4'b0000));
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rsp0      = NOR_TBL;
    if0.start = 1'b0;
    if1.start = 1'b0;
    rst       = 1'b0;
    #1 rst = 1'b1;
    #1;
    check_eq("rst_outs0", 32'({if0.a, if0.b, if0.busy, if0.done, if0.pass, if0.err_count, if0.fail_mask}), 32'd0);
    check_eq("rst_outs1", 32'({if1.a, if1.b, if1.busy, if1.done, if1.pass}), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Directed responses: correct NOR, stuck-at-0, stuck-at-1, OR gate.
    run0(4'b0001);
    run0(4'b0000);
    run0(4'b1111);
    run0(4'b1110);
    for (int i = 0; i < 6; i++) run0(4'($urandom_range(0, 15)));

    // Reset mid-run during vector 2 aborts without a done pulse.
    rsp0 = 4'b1111;
    @(negedge clk);
    if0.start = 1'b1;
    @(posedge clk);
    #1;
    if0.start = 1'b0;
    repeat (2 * S0) @(posedge clk);
    #1;
    check_eq("abort_vec", 32'({if0.a, if0.b}), 32'd2);
    check_eq("abort_err_pre", 32'(if0.err_count), 32'd1);
    #2 rst = 1'b1;
    #1;
    check_eq("abort_outs", 32'({if0.a, if0.b, if0.busy, if0.done, if0.pass, if0.err_count, if0.fail_mask}), 32'd0);
    repeat (3) begin
      @(posedge clk);
      #1;
      check_eq("abort_nodone", 32'(if0.done), 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    run0(4'b0001);

    // dut1: start held high, extra start toggling during busy/done.
    @(negedge clk);
    if1.start = 1'b1;
    @(posedge clk);
    #1;
    for (int t = 0; t < 6 * 4; t++) begin
      check_eq("b2b_busy", 32'(if1.busy), 32'((t % 6) < 4));
      check_eq("b2b_done", 32'(if1.done), 32'((t % 6) == 4));
      if ((t % 6) >= 4) begin
        check_eq("b2b_pass", 32'(if1.pass), 32'd1);
        check_eq("b2b_err", 32'(if1.err_count), 32'd0);
      end
      if1.start = ((t % 6) == 5) ? 1'b1 : 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
    if1.start = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
